// File: rtl/conv_ctrl.sv
// conv_ctrl: job sequencer for the 3-lane conv datapath. It reads channel groups, accumulates
// the lane results and emits output beats over valid/ready. Optional build macro: CONV_CTRL_RELU_EN.
module conv_ctrl #(
  parameter  int MAX_GROUPS = 16,
  parameter  int MAX_PIXELS = 256,
  parameter  int ADDR_W     = 12,
  parameter  int ACC_W      = 16,
  localparam int GRP_W      = $clog2(MAX_GROUPS) + 1,
  localparam int PIX_W      = $clog2(MAX_PIXELS) + 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_mode,
  input  logic [GRP_W-1:0]   i_numGroups,
  input  logic [PIX_W-1:0]   i_numPixels,
  output logic               o_opcode,
  output logic               o_rdEn,
  output logic [ADDR_W-1:0]  o_dataAddr,
  output logic [GRP_W-2:0]   o_weightAddr,
  input  logic [9:0]         i_convData0,
  input  logic [9:0]         i_convData1,
  input  logic [9:0]         i_convData2,
  output logic               o_outValid,
  input  logic               i_outReady,
  output logic [ACC_W-1:0]   o_outData0,
  output logic [ACC_W-1:0]   o_outData1,
  output logic [ACC_W-1:0]   o_outData2,
  output logic               o_busy,
  output logic               o_done
);
  typedef enum logic [2:0] {IDLE, READ, CAP, OUT, DONE} state_t;

  state_t              state;
  logic [GRP_W-1:0]    ng, ng_in, grp, grp_inc;
  logic [PIX_W-1:0]    np, np_in, pix, pix_inc;
  logic [ADDR_W-1:0]   lin, lin_inc;
  logic [ACC_W-1:0]    acc0, sx0, sx1, sx2, sum0, sum1, sum2;
  logic                last_grp, last_pix, hs;

  function automatic logic [ACC_W-1:0] relu(input logic [ACC_W-1:0] v);
`ifdef CONV_CTRL_RELU_EN
    relu = v[ACC_W-1] ? '0 : v;
`else
    relu = v;
`endif
  endfunction

  always_comb begin
    ng_in = (i_numGroups == '0) ? GRP_W'(1) :
            (i_numGroups > GRP_W'(MAX_GROUPS)) ? GRP_W'(MAX_GROUPS) : i_numGroups;
    np_in = (i_numPixels == '0) ? PIX_W'(1) :
            (i_numPixels > PIX_W'(MAX_PIXELS)) ? PIX_W'(MAX_PIXELS) : i_numPixels;
    sx0 = {{(ACC_W-10){i_convData0[9]}}, i_convData0};
    sx1 = {{(ACC_W-10){i_convData1[9]}}, i_convData1};
    sx2 = {{(ACC_W-10){i_convData2[9]}}, i_convData2};
    // DW never carries across groups; CONV restarts the sum on group 0 of each pixel
    sum0 = ((o_opcode || grp == '0) ? '0 : acc0) + sx0;
    sum1 = o_opcode ? sx1 : '0;
    sum2 = o_opcode ? sx2 : '0;
    last_grp = (grp == ng - 1'b1);
    last_pix = (pix == np - 1'b1);
    grp_inc  = last_grp ? '0 : grp + 1'b1;
    pix_inc  = last_grp ? pix + 1'b1 : pix;
    lin_inc  = lin + 1'b1;
    hs       = o_outValid & i_outReady;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      ng           <= '0;
      np           <= '0;
      grp          <= '0;
      pix          <= '0;
      lin          <= '0;
      acc0         <= '0;
      o_opcode     <= 1'b0;
      o_rdEn       <= 1'b0;
      o_dataAddr   <= '0;
      o_weightAddr <= '0;
      o_outValid   <= 1'b0;
      o_outData0   <= '0;
      o_outData1   <= '0;
      o_outData2   <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          state        <= READ;
          o_opcode     <= i_mode;
          ng           <= ng_in;
          np           <= np_in;
          grp          <= '0;
          pix          <= '0;
          lin          <= '0;
          o_dataAddr   <= '0;
          o_weightAddr <= '0;
          o_rdEn       <= 1'b1;
          o_busy       <= 1'b1;
        end
        READ: begin
          state  <= CAP;
          o_rdEn <= 1'b0;
        end
        CAP: begin
          acc0 <= sum0;
          if (!o_opcode && !last_grp) begin
            state        <= READ;
            o_rdEn       <= 1'b1;
            grp          <= grp_inc;
            lin          <= lin_inc;
            o_dataAddr   <= lin_inc;
            o_weightAddr <= grp_inc[GRP_W-2:0];
          end else begin
            state      <= OUT;
            o_outValid <= 1'b1;
            o_outData0 <= relu(sum0);
            o_outData1 <= relu(sum1);
            o_outData2 <= relu(sum2);
          end
        end
        OUT: if (hs) begin
          o_outValid <= 1'b0;
          o_outData0 <= '0;
          o_outData1 <= '0;
          o_outData2 <= '0;
          if (last_grp && last_pix) begin
            state  <= DONE;
            o_done <= 1'b1;
          end else begin
            state        <= READ;
            o_rdEn       <= 1'b1;
            grp          <= grp_inc;
            pix          <= pix_inc;
            lin          <= lin_inc;
            o_dataAddr   <= lin_inc;
            o_weightAddr <= grp_inc[GRP_W-2:0];
          end
        end
        DONE: begin
          state  <= IDLE;
          o_done <= 1'b0;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_ctrl.sv
// Bench for conv_ctrl: a buffer model feeds lane data by read address, and a job-level model
// predicts the read-address sequence and output beats, which are compared every cycle.
module tb_conv_ctrl;
  logic        i_clk = 1'b0, i_rst = 1'b1, i_start = 1'b0, i_mode = 1'b0, i_outReady = 1'b1;
  logic [4:0]  i_numGroups = '0;
  logic [8:0]  i_numPixels = '0;
  logic [9:0]  i_convData0 = '0, i_convData1 = '0, i_convData2 = '0;
  logic        o_opcode, o_rdEn, o_outValid, o_busy, o_done;
  logic [11:0] o_dataAddr;
  logic [3:0]  o_weightAddr;
  logic [15:0] o_outData0, o_outData1, o_outData2;

  conv_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
    .i_numGroups(i_numGroups), .i_numPixels(i_numPixels),
    .o_opcode(o_opcode), .o_rdEn(o_rdEn), .o_dataAddr(o_dataAddr), .o_weightAddr(o_weightAddr),
    .i_convData0(i_convData0), .i_convData1(i_convData1), .i_convData2(i_convData2),
    .o_outValid(o_outValid), .i_outReady(i_outReady),
    .o_outData0(o_outData0), .o_outData1(o_outData1), .o_outData2(o_outData2),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed { logic [15:0] d0, d1, d2; } beat_t;

  logic [9:0] mem0 [0:4095];
  logic [9:0] mem1 [0:4095];
  logic [9:0] mem2 [0:4095];
  int    exp_addr[$];
  int    exp_w[$];
  beat_t exp_beat[$];
  int    pass_cnt = 0, tot_cnt = 0;
  int    cyc = 0, start_cyc = 0, last_lat = 0, done_cnt = 0;
  logic  job_mode = 1'b0;
  int    job_ng = 1;
  bit    got_first = 0, prev_hs = 0, rdy_rand = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // buffer with one-cycle read latency
  always @(posedge i_clk) if (o_rdEn) begin
    i_convData0 <= mem0[o_dataAddr];
    i_convData1 <= mem1[o_dataAddr];
    i_convData2 <= mem2[o_dataAddr];
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [15:0] sx(input logic [9:0] v);
    return {{6{v[9]}}, v};
  endfunction

  function automatic logic [15:0] rl(input logic [15:0] v);
`ifdef CONV_CTRL_RELU_EN
    return v[15] ? 16'h0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int clampv(input int v, input int mx);
    return (v == 0) ? 1 : (v > mx) ? mx : v;
  endfunction

  // Job-level model: linear read order, then a sum per pixel (CONV) or a beat per read (DW)
  task automatic build_model(input logic mode, input int ngr, input int npr);
    int ng, np, a;
    beat_t b;
    logic [15:0] sum;
    ng = clampv(ngr, 16);
    np = clampv(npr, 256);
    exp_addr.delete(); exp_w.delete(); exp_beat.delete();
    for (int p = 0; p < np; p++) begin
      sum = '0;
      for (int g = 0; g < ng; g++) begin
        a = p * ng + g;
        exp_addr.push_back(a);
        exp_w.push_back(g);
        sum = sum + sx(mem0[a]);
        if (mode) begin
          b.d0 = rl(sx(mem0[a])); b.d1 = rl(sx(mem1[a])); b.d2 = rl(sx(mem2[a]));
          exp_beat.push_back(b);
        end
      end
      if (!mode) begin
        b.d0 = rl(sum); b.d1 = '0; b.d2 = '0;
        exp_beat.push_back(b);
      end
    end
    job_mode = mode;
    job_ng   = ng;
  endtask

  task automatic start_job(input logic mode, input int ngr, input int npr);
    got_first = 0;
    done_cnt  = 0;
    @(posedge i_clk); #2;
    i_mode = mode; i_numGroups = 5'(ngr); i_numPixels = 9'(npr); i_start = 1'b1;
    @(posedge i_clk); #2;
    i_start   = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int bound, input bit start_in_done);
    int t;
    t = 0;
    while (done_cnt == 0 && t < bound) begin
      @(negedge i_clk); #1;
      t++;
    end
    chk("job_done_seen", done_cnt > 0, 1);
    if (start_in_done && done_cnt > 0) begin
      i_mode = ~job_mode; i_start = 1'b1;
      @(posedge i_clk); #2;
      i_start = 1'b0;
      @(negedge i_clk); #1;
      chk("start_in_done_ignored", o_busy, 0);
    end else begin
      @(negedge i_clk); #1;
    end
    @(negedge i_clk); #1;
    chk("done_once", done_cnt, 1);
    chk("reads_consumed", exp_addr.size(), 0);
    chk("beats_consumed", exp_beat.size(), 0);
  endtask

  task automatic rand_mem(input int n);
    for (int i = 0; i < n; i++) begin
      mem0[i] = 10'($urandom); mem1[i] = 10'($urandom); mem2[i] = 10'($urandom);
    end
  endtask

  always @(posedge i_clk) begin
    #2;
    if (rdy_rand) i_outReady = ($urandom_range(0, 3) != 0);
  end

  // single per-cycle compare against the model queues
  always @(negedge i_clk) begin
    if (!i_rst) begin : cmp
      bit hs;
      hs = 0;
      if (o_busy) chk("opcode", o_opcode, job_mode);
      if (prev_hs && exp_addr.size() > 0) chk("read_after_hs", o_rdEn, 1);
      if (o_rdEn) begin
        if (exp_addr.size() == 0) chk("read_unexpected", 1, 0);
        else begin
          chk("data_addr", o_dataAddr, exp_addr[0]);
          chk("weight_addr", o_weightAddr, exp_w[0]);
          void'(exp_addr.pop_front());
          void'(exp_w.pop_front());
        end
        chk("read_while_valid", o_outValid, 0);
      end
      if (o_outValid) begin
        if (!got_first) begin
          got_first = 1;
          last_lat  = cyc - start_cyc;
          chk("first_valid_lat", last_lat, job_mode ? 2 : 2 * job_ng);
        end
        if (exp_beat.size() == 0) chk("beat_unexpected", 1, 0);
        else begin
          chk("out0", o_outData0, exp_beat[0].d0);
          chk("out1", o_outData1, exp_beat[0].d1);
          chk("out2", o_outData2, exp_beat[0].d2);
          if (i_outReady) begin
            void'(exp_beat.pop_front());
            hs = 1;
          end
        end
      end
      if (o_done) begin
        done_cnt++;
        chk("done_after_last_beat", exp_beat.size(), 0);
      end
      prev_hs = hs;
    end
  end

  initial begin
    int t, ngr, npr;
    logic m;
    rand_mem(4096);
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_outValid, 0);
    chk("rst_rden", o_rdEn, 0);
    chk("rst_out0", o_outData0, 0);
    chk("rst_addr", o_dataAddr, 0);
    i_rst = 1'b0;

    // 1: CONV 4 groups x 2 pixels, data0 = 5
    for (int i = 0; i < 8; i++) mem0[i] = 10'd5;
    build_model(1'b0, 4, 2);
    chk("model_t1_beat0", exp_beat[0].d0, 20);
    chk("model_t1_beat1", exp_beat[1].d0, 20);
    start_job(1'b0, 4, 2);
    wait_done(100, 1'b0);
    chk("t1_latency", last_lat, 8);

    // 2: negative wrap
    mem0[0] = 10'h3FE; mem0[1] = 10'h3FF;
    build_model(1'b0, 2, 1);
`ifdef CONV_CTRL_RELU_EN
    chk("model_t2", exp_beat[0].d0, 16'h0000);
`else
    chk("model_t2", exp_beat[0].d0, 16'hFFFD);
`endif
    start_job(1'b0, 2, 1);
    wait_done(100, 1'b0);

    // 3: depthwise, start pulsed during DONE
    mem0[0] = 10'd1; mem1[0] = 10'd2; mem2[0] = 10'd3;
    mem0[1] = 10'd4; mem1[1] = 10'd5; mem2[1] = 10'd6;
    build_model(1'b1, 2, 1);
    chk("model_t3_b0", exp_beat[0], {16'd1, 16'd2, 16'd3});
    chk("model_t3_b1", exp_beat[1], {16'd4, 16'd5, 16'd6});
    start_job(1'b1, 2, 1);
    wait_done(100, 1'b1);

    // 4: backpressure
    rand_mem(8);
    i_outReady = 1'b0;
    build_model(1'b0, 2, 2);
    start_job(1'b0, 2, 2);
    t = 0;
    while (!o_outValid && t < 50) begin @(negedge i_clk); #1; t++; end
    chk("bp_valid_seen", o_outValid, 1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", o_outValid, 1);
      chk("bp_no_read", o_rdEn, 0);
      @(negedge i_clk); #1;
    end
    @(posedge i_clk); #2;
    i_outReady = 1'b1;
    wait_done(100, 1'b0);

    // 5: reset during the 3rd group
    rand_mem(8);
    build_model(1'b0, 4, 2);
    start_job(1'b0, 4, 2);
    t = 0;
    while (!(o_rdEn && o_dataAddr == 12'd2) && t < 50) begin @(negedge i_clk); #1; t++; end
    chk("rst_t5_third_group", o_dataAddr, 2);
    i_rst = 1'b1;
    @(negedge i_clk); #1;
    chk("t5_busy", o_busy, 0);
    chk("t5_rden", o_rdEn, 0);
    chk("t5_valid", o_outValid, 0);
    chk("t5_opcode", o_opcode, 0);
    chk("t5_data", {o_outData0, o_outData1, o_outData2}, 0);
    exp_addr.delete(); exp_w.delete(); exp_beat.delete();
    prev_hs = 0; done_cnt = 0;
    i_rst = 1'b0;
    repeat (5) @(negedge i_clk);
    #1;
    chk("t5_no_done", done_cnt, 0);
    build_model(1'b0, 4, 2);
    start_job(1'b0, 4, 2);
    wait_done(100, 1'b0);

    // 6: zero config clamps to 1/1; then a start while busy must be ignored
    build_model(1'b0, 0, 0);
    start_job(1'b0, 0, 0);
    wait_done(50, 1'b0);
    chk("t6_latency", last_lat, 2);
    rand_mem(6);
    build_model(1'b0, 3, 2);
    start_job(1'b0, 3, 2);
    repeat (3) @(posedge i_clk);
    #2;
    i_mode = 1'b1; i_numGroups = 5'd5; i_numPixels = 9'd7; i_start = 1'b1;
    @(posedge i_clk); #2;
    i_start = 1'b0;
    wait_done(100, 1'b0);

    // randomized jobs with random backpressure
    rdy_rand = 1;
    for (int j = 0; j < 20; j++) begin
      m   = 1'($urandom);
      ngr = $urandom_range(0, 20);
      npr = $urandom_range(0, 5);
      if (j == 7) begin ngr = 1; npr = 300; end
      rand_mem(clampv(ngr, 16) * clampv(npr, 256));
      build_model(m, ngr, npr);
      start_job(m, ngr, npr);
      wait_done(40 * clampv(ngr, 16) * clampv(npr, 256) + 100, 1'b0);
    end
    rdy_rand = 0;
    i_outReady = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
